mcb_traffic_checker: RTL and testbench

// - Self-checking DDR3 traffic engine on one MCB native user port (Spartan-6 MIG, port 0 style).
// - Starts after calibration: writes a deterministic pattern over [ADDR_START, ADDR_END), reads it back and compares.
// - Repeats for NUM_PASSES passes and reports pass/fail to top level (LED) and benches.
// - Generalises the single-port calib-done-only flow: data width, burst length, address window, pattern mode and pass count are all parametrised.

---
 rtl/mcb_tc_pkg.sv | 31 +++
 rtl/mcb_tc_patgen.sv | 32 +++
 rtl/mcb_traffic_checker.sv | 197 +++++++++++++++++++
 tb/tb_mcb_traffic_checker.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcb_tc_pkg.sv
// Shared constants and types for the MCB traffic checker: command codes, FSM states, pattern modes.
package mcb_tc_pkg;

    localparam logic [2:0] MCB_INSTR_WR = 3'b000;
    localparam logic [2:0] MCB_INSTR_RD = 3'b001;

    localparam int unsigned PAT_ADDR      = 0;
    localparam int unsigned PAT_INV_ADDR  = 1;
    localparam int unsigned PAT_ADDR_SEED = 2;

    localparam int unsigned WCNT_W  = 7;
    localparam int unsigned PASS_W  = 16;
    localparam int unsigned ERR_W   = 16;
    localparam logic [15:0] SEED_LO = 16'hA5C3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_CMD,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_PASS_END,
        ST_DONE
    } state_t;

    // Per-pass seed so that stale data from an earlier pass never matches.
    function automatic logic [31:0] make_seed(input logic [PASS_W-1:0] pass_cnt);
        return {pass_cnt, SEED_LO};
    endfunction

endpackage

// File: rtl/mcb_tc_patgen.sv
// Combinational pattern word for a byte address; used by both the write and the compare paths.
module mcb_tc_patgen
    import mcb_tc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned PATTERN    = 0
) (
    input  logic [ADDR_WIDTH-1:0] wa_i,
    input  logic [31:0]           seed_i,
    output logic [DATA_WIDTH-1:0] word_o
);

    localparam int unsigned REPS = DATA_WIDTH / 32;

    logic [31:0] wa32;
    logic [31:0] p;

    assign wa32 = 32'(wa_i);

    always_comb begin
        p = wa32;
        if (PATTERN == PAT_INV_ADDR) begin
            p = ~wa32;
        end else if (PATTERN == PAT_ADDR_SEED) begin
            p = wa32 ^ seed_i;
        end
    end

    assign word_o = {REPS{p}};

endmodule

// File: rtl/mcb_traffic_checker.sv
// Write/read-back/compare traffic engine for one Spartan-6 MCB user port.
module mcb_traffic_checker
    import mcb_tc_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 128,
    parameter int unsigned           ADDR_WIDTH = 30,
    parameter int unsigned           BURST_LEN  = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_START = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_END   = ADDR_WIDTH'(32'h4000),
    parameter int unsigned           PATTERN    = 0,
    parameter int unsigned           NUM_PASSES = 1,
    localparam int unsigned          MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  calib_done,
    input  logic                  start,
    output logic                  cmd_en,
    output logic [2:0]            cmd_instr,
    output logic [5:0]            cmd_bl,
    output logic [ADDR_WIDTH-1:0] cmd_byte_addr,
    input  logic                  cmd_full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [MASK_WIDTH-1:0] wr_mask,
    input  logic                  wr_full,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_empty,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam int unsigned     BURST_BYTES = BURST_LEN * MASK_WIDTH;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(BURST_LEN - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   burst_addr_q, burst_addr_d;
    logic [WCNT_W-1:0]       word_cnt_q, word_cnt_d;
    logic [PASS_W-1:0]       pass_cnt_q, pass_cnt_d;
    logic [ERR_W-1:0]        err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;
    logic                    busy_q, done_q, pass_q;

    logic [ADDR_WIDTH-1:0]   wa;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [DATA_WIDTH-1:0]   pat_word;

    assign wa        = burst_addr_q + ADDR_WIDTH'(word_cnt_q) * ADDR_WIDTH'(MASK_WIDTH);
    assign next_addr = burst_addr_q + ADDR_WIDTH'(BURST_BYTES);

    mcb_tc_patgen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PATTERN    (PATTERN)
    ) u_patgen (
        .wa_i   (wa),
        .seed_i (make_seed(pass_cnt_q)),
        .word_o (pat_word)
    );

    // Strobes are decoded from the registered state so they can honour full/empty in the same cycle.
    always_comb begin
        state_d          = state_q;
        burst_addr_d     = burst_addr_q;
        word_cnt_d       = word_cnt_q;
        pass_cnt_d       = pass_cnt_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        cmd_en           = 1'b0;
        cmd_instr        = 3'b000;
        cmd_bl           = 6'd0;
        cmd_byte_addr    = '0;
        wr_en            = 1'b0;
        wr_data          = '0;
        rd_en            = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (calib_done && start) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                wr_data = pat_word;
                if (word_cnt_q == '0 && !start) begin
                    state_d = ST_DONE;
                end else if (!wr_full) begin
                    wr_en = 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        state_d    = ST_WR_CMD;
                    end else begin
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                    end
                end
            end
            ST_WR_CMD: begin
                cmd_instr     = MCB_INSTR_WR;
                cmd_bl        = 6'(BURST_LEN - 1);
                cmd_byte_addr = burst_addr_q;
                if (!cmd_full) begin
                    cmd_en = 1'b1;
                    if (next_addr == ADDR_END) begin
                        burst_addr_d = ADDR_START;
                        state_d      = ST_RD_CMD;
                    end else begin
                        burst_addr_d = next_addr;
                        state_d      = ST_WR_DATA;
                    end
                end
            end
            ST_RD_CMD: begin
                cmd_instr     = MCB_INSTR_RD;
                cmd_bl        = 6'(BURST_LEN - 1);
                cmd_byte_addr = burst_addr_q;
                if (!start) begin
                    state_d = ST_DONE;
                end else if (!cmd_full) begin
                    cmd_en  = 1'b1;
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (!rd_empty) begin
                    rd_en = 1'b1;
                    if (rd_data != pat_word) begin
                        if (err_count_q == '0) first_err_addr_d = wa;
                        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                    end
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        if (next_addr == ADDR_END) begin
                            burst_addr_d = ADDR_START;
                            state_d      = ST_PASS_END;
                        end else begin
                            burst_addr_d = next_addr;
                            state_d      = ST_RD_CMD;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                    end
                end
            end
            ST_PASS_END: begin
                pass_cnt_d = pass_cnt_q + PASS_W'(1);
                if (NUM_PASSES != 0 && pass_cnt_d == PASS_W'(NUM_PASSES)) begin
                    state_d = ST_DONE;
                end else if (!start) begin
                    state_d = ST_DONE;
                end else begin
                    burst_addr_d = ADDR_START;
                    state_d      = ST_WR_DATA;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            burst_addr_q     <= ADDR_START;
            word_cnt_q       <= '0;
            pass_cnt_q       <= '0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            burst_addr_q     <= burst_addr_d;
            word_cnt_q       <= word_cnt_d;
            pass_cnt_q       <= pass_cnt_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            busy_q           <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done_q           <= (state_d == ST_DONE);
            pass_q           <= (state_d == ST_DONE) && (err_count_d == '0);
        end
    end

    assign wr_mask        = '0;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_mcb_traffic_checker.sv
// Directed bench: two checker instances (address pattern / seeded 3-pass) on behavioural MCB port models.
module tb_mcb_traffic_checker;

    localparam int unsigned DW  = 128;
    localparam int unsigned AW  = 30;
    localparam int unsigned MW  = DW / 8;
    localparam int unsigned BL  = 32;
    localparam int unsigned BPP = 32;   // bursts per pass over 0..0x4000

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst [2];
    logic          calib [2];
    logic          start [2];
    logic          block_en [2];
    logic          corrupt_en [2];
    logic [AW-1:0] corrupt_addr [2];
    int            corrupt_pass [2];

    logic          done_v [2];
    logic          pass_v [2];
    logic          busy_v [2];
    logic          zero_v [2];
    logic [15:0]   err_v [2];
    logic [AW-1:0] ferr_v [2];
    logic [AW-1:0] lastwr_v [2];
    int            wrc_v [2];
    int            rdc_v [2];

    task automatic chk(input int d, input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL dut%0d %s: observed=%0h expected=%0h", d, tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int unsigned pat, input logic [AW-1:0] wa, input int passidx);
        logic [31:0] p;
        logic [31:0] pi;
        pi = passidx;
        p  = {2'b00, wa};
        if (pat == 1) p = ~p;
        else if (pat == 2) p = p ^ {pi[15:0], 16'hA5C3};
        return {4{p}};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_mcb
        localparam int unsigned PAT = (g == 0) ? 0 : 2;
        localparam int unsigned NP  = (g == 0) ? 1 : 3;

        logic          cmd_en, cmd_full, wr_en, wr_full, rd_en, rd_empty;
        logic          busy, done, pass;
        logic [2:0]    cmd_instr;
        logic [5:0]    cmd_bl;
        logic [AW-1:0] cmd_addr, ferr;
        logic [DW-1:0] wr_data, rd_data;
        logic [MW-1:0] wr_mask;
        logic [15:0]   err;

        logic [DW-1:0] mem [1024];
        logic [32:0]   cq [$];
        logic [DW-1:0] wq [$];
        logic [DW-1:0] rq [$];
        logic [DW-1:0] pend_d [$];
        int            pend_t [$];
        int            wr_cmds, rd_cmds, wr_bursts, rd_bursts;
        logic [AW-1:0] exp_wr_addr, exp_rd_addr, last_wr_addr;

        mcb_traffic_checker #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .BURST_LEN  (BL),
            .ADDR_START (30'h0),
            .ADDR_END   (30'h4000),
            .PATTERN    (PAT),
            .NUM_PASSES (NP)
        ) u_dut (
            .clk            (clk),
            .rst            (rst[g]),
            .calib_done     (calib[g]),
            .start          (start[g]),
            .cmd_en         (cmd_en),
            .cmd_instr      (cmd_instr),
            .cmd_bl         (cmd_bl),
            .cmd_byte_addr  (cmd_addr),
            .cmd_full       (cmd_full),
            .wr_en          (wr_en),
            .wr_data        (wr_data),
            .wr_mask        (wr_mask),
            .wr_full        (wr_full),
            .rd_en          (rd_en),
            .rd_data        (rd_data),
            .rd_empty       (rd_empty),
            .busy           (busy),
            .done           (done),
            .pass           (pass),
            .err_count      (err),
            .first_err_addr (ferr)
        );

        assign done_v[g]   = done;
        assign pass_v[g]   = pass;
        assign busy_v[g]   = busy;
        assign err_v[g]    = err;
        assign ferr_v[g]   = ferr;
        assign lastwr_v[g] = last_wr_addr;
        assign wrc_v[g]    = wr_cmds;
        assign rdc_v[g]    = rd_cmds;
        assign zero_v[g]   = |{cmd_en, cmd_instr, cmd_bl, cmd_addr, wr_en, wr_data, wr_mask,
                               rd_en, busy, done, pass, err, ferr};

        // MCB port model: 4-deep cmd FIFO, 64-deep data FIFOs, 10-cycle read latency.
        always @(posedge clk) begin
            logic [32:0]   h;
            logic [AW-1:0] a;
            logic [DW-1:0] w;
            int            nbad;
            if (rst[g]) begin
                cq.delete(); wq.delete(); rq.delete(); pend_d.delete(); pend_t.delete();
                wr_cmds = 0; rd_cmds = 0; wr_bursts = 0; rd_bursts = 0;
                exp_wr_addr = '0; exp_rd_addr = '0; last_wr_addr = '0;
                cmd_full <= 1'b0; wr_full <= 1'b0; rd_empty <= 1'b1; rd_data <= '0;
            end else begin
                if (cmd_en) begin
                    chk(g, "cmd_en_while_full", cmd_full, 1'b0);
                    if (cmd_instr == 3'b000) begin
                        chk(g, "wr_cmd_bl_addr", {cmd_bl, cmd_addr}, {6'd31, exp_wr_addr});
                        last_wr_addr = cmd_addr;
                        wr_cmds++;
                        exp_wr_addr = (exp_wr_addr + 30'h200 == 30'h4000) ? 30'h0 : exp_wr_addr + 30'h200;
                    end else begin
                        chk(g, "rd_cmd_instr_bl_addr", {cmd_instr, cmd_bl, cmd_addr}, {3'b001, 6'd31, exp_rd_addr});
                        rd_cmds++;
                        exp_rd_addr = (exp_rd_addr + 30'h200 == 30'h4000) ? 30'h0 : exp_rd_addr + 30'h200;
                    end
                    cq.push_back({cmd_instr, cmd_addr});
                end
                if (wr_en) begin
                    chk(g, "wr_en_while_full", wr_full, 1'b0);
                    wq.push_back(wr_data);
                end
                if (rd_en) begin
                    chk(g, "rd_en_while_empty", rd_empty, 1'b0);
                    if (rq.size() > 0) rq.delete(0);
                end
                if (cq.size() > 0) begin
                    h = cq[0];
                    if (h[32:30] == 3'b000) begin
                        if (wq.size() >= BL) begin
                            nbad = 0;
                            for (int i = 0; i < BL; i++) begin
                                a = h[29:0] + AW'(i * MW);
                                w = wq.pop_front();
                                if (w !== exp_word(PAT, a, wr_bursts / BPP)) nbad++;
                                mem[a[13:4]] = w;
                            end
                            chk(g, "wr_burst_bad_words", 128'(nbad), 128'd0);
                            wr_bursts++;
                            cq.delete(0);
                        end
                    end else begin
                        for (int i = 0; i < BL; i++) begin
                            a = h[29:0] + AW'(i * MW);
                            w = mem[a[13:4]];
                            if (corrupt_en[g] && a == corrupt_addr[g] &&
                                (corrupt_pass[g] < 0 || corrupt_pass[g] == rd_bursts / BPP)) w[5] = ~w[5];
                            pend_d.push_back(w);
                            pend_t.push_back(cyc + 10);
                        end
                        rd_bursts++;
                        cq.delete(0);
                    end
                end
                while (pend_t.size() > 0 && pend_t[0] <= cyc) begin
                    rq.push_back(pend_d.pop_front());
                    pend_t.delete(0);
                end
                cmd_full <= (cq.size() >= 4)  || (block_en[g] && ($urandom & 1) == 1);
                wr_full  <= (wq.size() >= 64) || (block_en[g] && ($urandom & 1) == 1);
                rd_empty <= (rq.size() == 0)  || (block_en[g] && ($urandom & 1) == 1);
                rd_data  <= (rq.size() > 0) ? rq[0] : '0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1; start[d] = 1'b0; calib[d] = 1'b0;
        tick(2);
        chk(d, "reset_outputs_zero", zero_v[d], 1'b0);
        rst[d] = 1'b0;
        tick(1);
    endtask

    task automatic run_until_done(input int d, input int budget, input string tag);
        int n = 0;
        calib[d] = 1'b1; start[d] = 1'b1;
        while (!done_v[d] && n < budget) begin tick(1); n++; end
        chk(d, tag, done_v[d], 1'b1);
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; calib[d] = 1'b0; start[d] = 1'b0; block_en[d] = 1'b0;
            corrupt_en[d] = 1'b0; corrupt_addr[d] = '0; corrupt_pass[d] = -1;
        end
        tick(4);
        chk(0, "reset_outputs_zero", zero_v[0], 1'b0);
        chk(1, "reset_outputs_zero", zero_v[1], 1'b0);

        // start without calibration must stay idle
        rst[0] = 1'b0; start[0] = 1'b1;
        tick(4);
        chk(0, "idle_without_calib_busy", busy_v[0], 1'b0);
        chk(0, "idle_without_calib_cmds", wrc_v[0], 0);

        // full single pass, clean memory
        run_until_done(0, 20000, "t1_done");
        chk(0, "t1_pass", pass_v[0], 1'b1);
        chk(0, "t1_err_count", err_v[0], 16'd0);
        chk(0, "t1_wr_cmds", wrc_v[0], 32);
        chk(0, "t1_rd_cmds", rdc_v[0], 32);
        chk(0, "t1_busy_after_done", busy_v[0], 1'b0);
        chk(0, "t1_mem_0x210", g_mcb[0].mem[33], {4{32'h00000210}});

        // single flipped bit at 0x210
        do_reset(0);
        corrupt_en[0] = 1'b1; corrupt_addr[0] = 30'h210; corrupt_pass[0] = -1;
        run_until_done(0, 20000, "t2_done");
        chk(0, "t2_err_count", err_v[0], 16'd1);
        chk(0, "t2_first_err_addr", ferr_v[0], 30'h210);
        chk(0, "t2_pass", pass_v[0], 1'b0);
        corrupt_en[0] = 1'b0;

        // random 50% back-pressure on every FIFO flag
        do_reset(0);
        block_en[0] = 1'b1;
        run_until_done(0, 40000, "t3_done");
        chk(0, "t3_pass", pass_v[0], 1'b1);
        chk(0, "t3_err_count", err_v[0], 16'd0);
        chk(0, "t3_wr_cmds", wrc_v[0], 32);
        chk(0, "t3_rd_cmds", rdc_v[0], 32);
        block_en[0] = 1'b0;

        // start dropped right after the 5th write command
        do_reset(0);
        calib[0] = 1'b1; start[0] = 1'b1;
        n = 0;
        while (wrc_v[0] < 5 && n < 2000) begin tick(1); n++; end
        chk(0, "t4_reached_5_wr_cmds", wrc_v[0], 5);
        start[0] = 1'b0;
        n = 0;
        while (!done_v[0] && n < 2 * BL + 8) begin tick(1); n++; end
        chk(0, "t4_done_in_time", done_v[0], 1'b1);
        tick(20);
        chk(0, "t4_no_more_wr_cmds", wrc_v[0], 5);
        chk(0, "t4_no_rd_cmds", rdc_v[0], 0);
        chk(0, "t4_pass", pass_v[0], 1'b1);

        // reset pulse while reading back
        do_reset(0);
        calib[0] = 1'b1; start[0] = 1'b1;
        n = 0;
        while (rdc_v[0] < 2 && n < 10000) begin tick(1); n++; end
        chk(0, "t5_in_read_phase", rdc_v[0], 2);
        rst[0] = 1'b1;
        tick(1);
        chk(0, "t5_outputs_zero_after_rst", zero_v[0], 1'b0);
        rst[0] = 1'b0;
        n = 0;
        while (wrc_v[0] < 1 && n < 200) begin tick(1); n++; end
        chk(0, "t5_restart_first_wr_addr", {wrc_v[0][7:0], lastwr_v[0]}, {8'd1, 30'h0});
        run_until_done(0, 20000, "t5_done");
        chk(0, "t5_pass", pass_v[0], 1'b1);

        // seeded pattern, three passes
        do_reset(1);
        run_until_done(1, 40000, "t6_done");
        chk(1, "t6_pass", pass_v[1], 1'b1);
        chk(1, "t6_err_count", err_v[1], 16'd0);
        chk(1, "t6_wr_cmds", wrc_v[1], 96);
        chk(1, "t6_rd_cmds", rdc_v[1], 96);
        chk(1, "t6_mem_0x000_pass3_seed", g_mcb[1].mem[0], {4{32'h0002A5C3}});
        chk(1, "t6_mem_0x210_pass3_seed", g_mcb[1].mem[33], {4{32'h0002A7D3}});

        // corrupt one word only during the second pass
        do_reset(1);
        corrupt_en[1] = 1'b1; corrupt_addr[1] = 30'h100; corrupt_pass[1] = 1;
        run_until_done(1, 40000, "t7_done");
        chk(1, "t7_err_count", err_v[1], 16'd1);
        chk(1, "t7_first_err_addr", ferr_v[1], 30'h100);
        chk(1, "t7_pass", pass_v[1], 1'b0);
        chk(1, "t7_wr_cmds", wrc_v[1], 96);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
